// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU word type, request-unit state enum, memory op type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } req_state_t;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_t;

    // A write request dominates, so a simultaneous read is dropped.
    function automatic mem_op_t resolve_mem_op(input logic wen);
        return wen ? MEM_WR : MEM_RD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/request_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : request_unit_if
// Description : Control-unit / memory-side bundle of the request unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface request_unit_if;
    import cpu_types_pkg::*;

    logic  iREN;
    logic  dREN;
    logic  dWEN;
    logic  halt;
    logic  ihit;
    logic  dhit;
    word_t imemload;
    word_t dmemload;
    word_t alu_out;
    word_t rdat2;

    word_t instruction;
    logic  imemREN;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    word_t load_data;
    logic  pc_en;
    logic  halt_out;
    logic  err;
    word_t retired;

    modport master (
        output iREN, dREN, dWEN, halt, ihit, dhit,
        output imemload, dmemload, alu_out, rdat2,
        input  instruction, imemREN, dmemREN, dmemWEN,
        input  dmemaddr, dmemstore, load_data, pc_en, halt_out, err, retired
    );

    modport slave (
        input  iREN, dREN, dWEN, halt, ihit, dhit,
        input  imemload, dmemload, alu_out, rdat2,
        output instruction, imemREN, dmemREN, dmemWEN,
        output dmemaddr, dmemstore, load_data, pc_en, halt_out, err, retired
    );

endinterface
`default_nettype wire

// File: rtl/request_timer.sv
`default_nettype none
// ============================================================================
// Module      : request_timer
// Description : Wait watchdog; expires on the (2^TIMEOUT_W-1)th wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module request_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] c_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] c_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] r_count;

    // Any non-wait cycle (a hit or a different state) restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_wait) begin
            r_count <= '0;
        end else if (!o_expired) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_expired = i_wait && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/request_unit.sv
`default_nettype none
// ============================================================================
// Module      : request_unit
// Description : Fetch/exec/mem request sequencer; optional watchdog under
//               REQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    request_unit_if.slave bus
);

    req_state_t r_state;
    req_state_t w_state_nxt;
    mem_op_t    r_mem_op;
    word_t      r_instruction;
    word_t      r_dmemaddr;
    word_t      r_dmemstore;
    word_t      r_load_data;
    word_t      r_retired;
    logic       w_pc_en;
    logic       w_expired;
    logic       w_mem_issue;
    logic       w_dhit_mem;

    assign w_mem_issue = (r_state == EXEC) && !bus.halt && (bus.dWEN || bus.dREN);
    assign w_dhit_mem  = (r_state == MEM) && bus.dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_en     = 1'b0;
        case (r_state)
            FETCH: begin
                if (w_expired) begin
                    w_state_nxt = HALT;
                end else if (bus.ihit) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (bus.halt) begin
                    w_state_nxt = HALT;
                end else if (bus.dWEN || bus.dREN) begin
                    w_state_nxt = MEM;
                end else begin
                    w_pc_en     = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            MEM: begin
                if (w_expired) begin
                    w_state_nxt = HALT;
                end else if (bus.dhit) begin
                    w_pc_en     = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instruction <= '0;
            r_dmemaddr    <= '0;
            r_dmemstore   <= '0;
            r_load_data   <= '0;
            r_retired     <= '0;
            r_mem_op      <= MEM_RD;
        end else begin
            if ((r_state == FETCH) && bus.ihit) begin
                r_instruction <= bus.imemload;
            end
            // Address, data and op type are frozen here so MEM ignores live inputs.
            if (w_mem_issue) begin
                r_dmemaddr  <= bus.alu_out;
                r_dmemstore <= bus.rdat2;
                r_mem_op    <= resolve_mem_op(bus.dWEN);
            end
            if (w_dhit_mem && (r_mem_op == MEM_RD)) begin
                r_load_data <= bus.dmemload;
            end
            if (w_pc_en) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

`ifdef REQ_TIMEOUT_EN
    logic w_wait;
    logic r_err;

    assign w_wait = ((r_state == FETCH) && !bus.ihit) || ((r_state == MEM) && !bus.dhit);

    request_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_request_timer (
        .clk       (CLK),
        .rst_n     (nRST),
        .i_wait    (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_err <= 1'b0;
        end else if (w_expired) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_expired = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Requests decode from state only; hit strobes never reach them combinationally.
    assign bus.imemREN     = (r_state == FETCH) && bus.iREN;
    assign bus.dmemREN     = (r_state == MEM) && (r_mem_op == MEM_RD);
    assign bus.dmemWEN     = (r_state == MEM) && (r_mem_op == MEM_WR);
    assign bus.pc_en       = w_pc_en;
    assign bus.halt_out    = (r_state == HALT);
    assign bus.instruction = r_instruction;
    assign bus.dmemaddr    = r_dmemaddr;
    assign bus.dmemstore   = r_dmemstore;
    assign bus.load_data   = r_load_data;
    assign bus.retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_request_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_request_unit
// Description : Directed + randomized self-checking bench for request_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_request_unit;
    import cpu_types_pkg::*;

    localparam int c_TW      = 4;
    localparam int c_K_ALU   = 0;
    localparam int c_K_LOAD  = 1;
    localparam int c_K_STORE = 2;
    localparam int c_K_BOTH  = 3;
    localparam int c_K_HALT  = 4;

    logic  CLK  = 1'b0;
    logic  nRST = 1'b0;
    int    checks = 0;
    int    errors = 0;
    word_t exp_retired = '0;
    word_t exp_load    = '0;

    request_unit_if bus();

    request_unit #(
        .TIMEOUT_W (c_TW)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.iREN = 1'b1; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.halt = 1'b0;
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.imemload = '0; bus.dmemload = '0; bus.alu_out = '0; bus.rdat2 = '0;
    endtask

    // One whole instruction at transaction level; DUT assumed in FETCH on entry.
    task automatic run_instr(input int kind, input word_t instr, input int fdly,
                             input word_t addr, input word_t sdata,
                             input word_t ldata, input int mdly);
        logic is_mem;
        logic is_wr;
        is_mem = (kind == c_K_LOAD) || (kind == c_K_STORE) || (kind == c_K_BOTH);
        is_wr  = (kind == c_K_STORE) || (kind == c_K_BOTH);
        bus.iREN = 1'b1; bus.halt = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        for (int i = 0; i < fdly; i++) begin
            bus.ihit = 1'b0;
            bus.dhit = 1'($urandom_range(0, 1));
            bus.imemload = $urandom;
            #1;
            check("fetch_imemREN", bus.imemREN, 1);
            check("fetch_pc_en", bus.pc_en, 0);
            tick();
        end
        bus.ihit = 1'b1; bus.dhit = 1'b0; bus.imemload = instr;
        #1;
        check("fetch_hit_imemREN", bus.imemREN, 1);
        tick();
        check("instruction", bus.instruction, instr);
        bus.ihit = 1'($urandom_range(0, 1));
        bus.imemload = $urandom;
        bus.halt = (kind == c_K_HALT);
        bus.dWEN = is_wr || (kind == c_K_HALT);
        bus.dREN = (kind == c_K_LOAD) || (kind == c_K_BOTH);
        bus.alu_out = addr; bus.rdat2 = sdata;
        #1;
        check("exec_pc_en", bus.pc_en, (kind == c_K_ALU));
        check("exec_imemREN", bus.imemREN, 0);
        tick();
        bus.halt = 1'b0; bus.ihit = 1'b0;
        if (kind == c_K_HALT) begin
            check("halt_out", bus.halt_out, 1);
            check("halt_dmemWEN", bus.dmemWEN, 0);
        end else if (!is_mem) begin
            exp_retired++;
            check("alu_retired", bus.retired, exp_retired);
        end else begin
            for (int i = 0; i <= mdly; i++) begin
                bus.dhit = (i == mdly);
                bus.dmemload = (i == mdly) ? ldata : word_t'($urandom);
                bus.dREN = 1'($urandom_range(0, 1));
                bus.dWEN = 1'($urandom_range(0, 1));
                bus.alu_out = $urandom; bus.rdat2 = $urandom;
                #1;
                check("mem_dmemWEN", bus.dmemWEN, is_wr);
                check("mem_dmemREN", bus.dmemREN, !is_wr);
                check("mem_dmemaddr", bus.dmemaddr, addr);
                check("mem_dmemstore", bus.dmemstore, sdata);
                check("mem_pc_en", bus.pc_en, (i == mdly));
                tick();
            end
            bus.dhit = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
            if (!is_wr) exp_load = ldata;
            exp_retired++;
            check("post_dmemWEN", bus.dmemWEN, 0);
            check("post_dmemREN", bus.dmemREN, 0);
            check("load_data", bus.load_data, exp_load);
            check("mem_retired", bus.retired, exp_retired);
            check("post_imemREN", bus.imemREN, 1);
        end
    endtask

    initial begin
        quiet_inputs();
        nRST = 1'b0;
        tick();
        tick();
        check("rst_instruction", bus.instruction, 0);
        check("rst_dmemaddr", bus.dmemaddr, 0);
        check("rst_dmemstore", bus.dmemstore, 0);
        check("rst_load_data", bus.load_data, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_pc_en", bus.pc_en, 0);
        check("rst_dmemREN", bus.dmemREN, 0);
        check("rst_dmemWEN", bus.dmemWEN, 0);
        check("rst_halt_out", bus.halt_out, 0);
        check("rst_err", bus.err, 0);
        nRST = 1'b1;
        #1;
        check("release_imemREN", bus.imemREN, 1);

        run_instr(c_K_ALU, 32'h2001_0005, 1, '0, '0, '0, 0);
        run_instr(c_K_LOAD, 32'h8C01_0000, 0, 32'h0000_0100, 32'h1111_2222, 32'hDEAD_BEEF, 3);
        run_instr(c_K_BOTH, 32'hAC02_0000, 3, 32'h0000_0040, 32'h0000_CAFE, 32'h7777_7777, 1);

        for (int n = 0; n < 20; n++) begin
            run_instr($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                      $urandom, $urandom, $urandom, $urandom_range(0, 4));
        end

        // Reset in the middle of a store.
        bus.ihit = 1'b1; bus.imemload = 32'hAC03_0000;
        tick();
        bus.ihit = 1'b0; bus.dWEN = 1'b1; bus.alu_out = 32'h200; bus.rdat2 = 32'h55;
        tick();
        bus.dWEN = 1'b0;
        #1;
        check("pre_rst_dmemWEN", bus.dmemWEN, 1);
        nRST = 1'b0;
        bus.dhit = 1'b1; bus.dmemload = 32'h1234_5678;
        #1;
        exp_retired = '0; exp_load = '0;
        check("midrst_dmemWEN", bus.dmemWEN, 0);
        check("midrst_pc_en", bus.pc_en, 0);
        check("midrst_retired", bus.retired, 0);
        tick();
        check("midrst_load_data", bus.load_data, 0);
        quiet_inputs();
        nRST = 1'b1;
        #1;
        check("midrst_resume_imemREN", bus.imemREN, 1);
        run_instr(c_K_ALU, 32'h0000_0020, 0, '0, '0, '0, 0);

        // Fetch that never completes.
        nRST = 1'b0; #1; quiet_inputs(); tick(); nRST = 1'b1; #1;
        exp_retired = '0; exp_load = '0;
        for (int i = 0; i < 14; i++) tick();
        check("wd_err_before", bus.err, 0);
        check("wd_halt_before", bus.halt_out, 0);
        tick();
`ifdef REQ_TIMEOUT_EN
        check("wd_err", bus.err, 1);
        check("wd_halt_out", bus.halt_out, 1);
        check("wd_imemREN", bus.imemREN, 0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("nowd_err", bus.err, 0);
        check("nowd_halt_out", bus.halt_out, 0);
        check("nowd_imemREN", bus.imemREN, 1);
`endif

        // Halt beats a simultaneous store, then stays put.
        nRST = 1'b0; #1; quiet_inputs(); tick(); nRST = 1'b1; #1;
        run_instr(c_K_ALU, 32'h0000_0021, 0, '0, '0, '0, 0);
        run_instr(c_K_HALT, 32'hFC00_0000, 1, 32'h300, 32'h99, '0, 0);
        for (int i = 0; i < 100; i++) begin
            bus.iREN = 1'($urandom_range(0, 1)); bus.dREN = 1'($urandom_range(0, 1));
            bus.dWEN = 1'($urandom_range(0, 1)); bus.halt = 1'($urandom_range(0, 1));
            bus.ihit = 1'($urandom_range(0, 1)); bus.dhit = 1'($urandom_range(0, 1));
            bus.imemload = $urandom; bus.dmemload = $urandom;
            bus.alu_out = $urandom; bus.rdat2 = $urandom;
            #1;
            check("halt_hold", bus.halt_out, 1);
            check("halt_reqs", {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pc_en}, 0);
            tick();
        end
        check("halt_retired", bus.retired, exp_retired);
        check("halt_err", bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
